// File: rtl/ifu_pkg.sv
// Shared types and helpers for the image fetch unit: FSM state encoding,
// kernel-size clamping and the per-frame window count.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ifu_state_e;

    localparam int KER_SIZE_W = 3;

    // A zero kernel behaves as 1x1; anything beyond the window array saturates.
    function automatic logic [KER_SIZE_W-1:0] clamp_kernel(input logic [KER_SIZE_W-1:0] ks,
                                                           input int kmax);
        if (ks == '0) begin
            return KER_SIZE_W'(1);
        end else if (int'(ks) > kmax) begin
            return KER_SIZE_W'(kmax);
        end
        return ks;
    endfunction

    function automatic int window_count(input int w, input int k);
        return (w - k + 1) * (w - k + 1);
    endfunction

endpackage

// File: rtl/ifu_line_buffer.sv
// One image row of delay: circular buffer whose output is the word written
// DEPTH enabled cycles earlier (read happens before the write in the same cycle).
module ifu_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      ptr;

    assign dout = mem[ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; stale rows never reach a valid window.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/image_fetch_unit.sv
// Raster-order BRAM reader that builds a KxK stride-1 sliding window for the PE array.
// Define IFU_ASSERT_EN to compile in simulation-only protocol assertions.
module image_fetch_unit
    import ifu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 12,
    parameter int MAX_IMG_WIDTH   = 28,
    parameter int MAX_KERNEL_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [KER_SIZE_W-1:0] ker_size,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_din,
    output logic [DATA_WIDTH-1:0] pe_windows [0:MAX_KERNEL_SIZE-1][0:MAX_KERNEL_SIZE-1],
    output logic                  window_valid,
    output logic                  frame_done
);

    localparam int W     = MAX_IMG_WIDTH;
    localparam int M     = MAX_KERNEL_SIZE;
    localparam int NPIX  = W * W;
    localparam int IDX_W = $clog2(NPIX);
    localparam int POS_W = $clog2(W);

    ifu_state_e state, next_state;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [KER_SIZE_W-1:0] k_q;
    int                    k_int;
    logic [IDX_W-1:0]      fetch_idx;
    logic                  fetch_last;
    logic                  rd_vld;
    logic [POS_W-1:0]      cap_row, cap_col;
    logic                  cap_in_window, cap_is_last;
    logic                  last_q;

    logic [DATA_WIDTH-1:0] taps      [0:M-1][0:M-1];
    logic [DATA_WIDTH-1:0] taps_next [0:M-1][0:M-1];
    logic [DATA_WIDTH-1:0] lb_din    [M-1];
    logic [DATA_WIDTH-1:0] lb_dout   [M-1];

    assign k_int         = int'(k_q);
    assign fetch_last    = (fetch_idx == IDX_W'(NPIX - 1));
    assign cap_in_window = (int'(cap_row) >= k_int - 1) && (int'(cap_col) >= k_int - 1);
    assign cap_is_last   = (cap_row == POS_W'(W - 1)) && (cap_col == POS_W'(W - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (fetch_last) next_state = DRAIN;
            DRAIN:   if (last_q) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bram_en    = (state == FETCH);
        bram_addr  = bram_en ? base_q + ADDR_WIDTH'(fetch_idx) : '0;
        frame_done = (state == DONE);
    end

    // Frame bookkeeping: fetch index, read-return flag and captured pixel position.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_q       <= '0;
            k_q          <= KER_SIZE_W'(1);
            fetch_idx    <= '0;
            rd_vld       <= 1'b0;
            cap_row      <= '0;
            cap_col      <= '0;
            last_q       <= 1'b0;
            window_valid <= 1'b0;
        end else begin
            rd_vld       <= bram_en;
            last_q       <= rd_vld && cap_is_last;
            window_valid <= rd_vld && cap_in_window;
            if (state == IDLE && start) begin
                base_q    <= base_addr;
                k_q       <= clamp_kernel(ker_size, M);
                fetch_idx <= '0;
                cap_row   <= '0;
                cap_col   <= '0;
            end
            if (bram_en) begin
                fetch_idx <= fetch_idx + 1'b1;
            end
            if (rd_vld) begin
                if (cap_col == POS_W'(W - 1)) begin
                    cap_col <= '0;
                    cap_row <= cap_row + 1'b1;
                end else begin
                    cap_col <= cap_col + 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < M - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_din[j] = bram_din;
        end else begin : g_chain
            assign lb_din[j] = lb_dout[j-1];
        end
        ifu_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (W)
        ) u_line_buffer (
            .clk (clk),
            .rstn(rstn),
            .en  (rd_vld),
            .din (lb_din[j]),
            .dout(lb_dout[j])
        );
    end

    // Row K-1 takes the new pixel; row r takes the pixel (K-1-r) rows above it.
    always_comb begin
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                taps_next[r][c] = '0;
            end
        end
        for (int r = 0; r < M; r++) begin
            logic [DATA_WIDTH-1:0] row_in;
            row_in = '0;
            if (r == k_int - 1) begin
                row_in = bram_din;
            end
            for (int j = 0; j < M - 1; j++) begin
                if (j == k_int - 2 - r) begin
                    row_in = lb_dout[j];
                end
            end
            if (r < k_int) begin
                for (int c = 0; c < M - 1; c++) begin
                    if (c < k_int - 1) begin
                        taps_next[r][c] = taps[r][c+1];
                    end
                end
                for (int c = 0; c < M; c++) begin
                    if (c == k_int - 1) begin
                        taps_next[r][c] = row_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld) begin
            taps <= taps_next;
        end
    end

    // The visible window only changes on a valid capture so it holds between strobes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    pe_windows[r][c] <= '0;
                end
            end
        end else if (rd_vld && cap_in_window) begin
            pe_windows <= taps_next;
        end
    end

`ifdef IFU_ASSERT_EN
    int win_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || frame_done) begin
            win_cnt <= 0;
        end else if (window_valid) begin
            win_cnt <= win_cnt + 1;
        end
    end

    a_en_idle: assert property (@(posedge clk) disable iff (!rstn)
        (state == IDLE || state == DONE) |-> !bram_en);
    a_ker_range: assert property (@(posedge clk) disable iff (!rstn)
        (state == IDLE && start) |-> (ker_size != '0 && int'(ker_size) <= M));
    a_win_count: assert property (@(posedge clk) disable iff (!rstn)
        frame_done |-> (win_cnt == window_count(W, k_int)));
    a_done_pulse: assert property (@(posedge clk) disable iff (!rstn)
        frame_done |=> !frame_done);
`endif

endmodule

// File: tb/tb_image_fetch_unit.sv
// Directed bench for image_fetch_unit on an 8x8 image whose BRAM word i holds i.
module tb_image_fetch_unit;

    localparam int W    = 8;
    localparam int KMAX = 5;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [11:0] base_addr;
    logic [2:0]  ker_size;
    logic        bram_en;
    logic [11:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] pe_windows [0:KMAX-1][0:KMAX-1];
    logic        window_valid;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  k;
        logic [11:0] base;
        bit          poke;
        int          exp_windows;
        logic [31:0] exp_first_tl;
        logic [31:0] exp_last_tl;
        logic [31:0] exp_last_br;
    } vec_t;

    vec_t vecs [6];

    image_fetch_unit #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (12),
        .MAX_IMG_WIDTH  (W),
        .MAX_KERNEL_SIZE(KMAX)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .ker_size    (ker_size),
        .bram_en     (bram_en),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .pe_windows  (pe_windows),
        .window_valid(window_valid),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial bram_din = '0;
    always @(posedge clk) begin
        if (bram_en) bram_din <= 32'(bram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a frame, then check every output cycle by cycle against a raster model.
    task automatic run_frame(input logic [2:0] k, input logic [11:0] base, input bit poke,
                             input int cycles, output int wcnt, output logic [31:0] first_tl,
                             output logic [31:0] last_tl, output logic [31:0] last_br);
        int ki, nw, p, r0, c0;
        logic [31:0] e;
        logic [2:0]  km1;
        ki = int'(k);
        km1 = 3'(ki - 1);
        nw = W - ki + 1;
        wcnt = 0;
        first_tl = '0;
        last_tl = '0;
        last_br = '0;
        @(negedge clk);
        start = 1'b1;
        ker_size = k;
        base_addr = base;
        @(posedge clk);
        for (int cyc = 1; cyc <= cycles; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (poke && cyc == 10) begin
                start = 1'b1;
                ker_size = 3'd2;
                base_addr = 12'd500;
            end
            if (poke && cyc == 11) start = 1'b0;
            check("bram_en", 32'(bram_en), 32'(cyc <= W * W));
            if (cyc <= W * W) check("bram_addr", 32'(bram_addr), 32'((int'(base) + cyc - 1) % 4096));
            p = cyc - 3;
            check("window_valid", 32'(window_valid),
                  32'(p >= 0 && p < W * W && p / W >= ki - 1 && p % W >= ki - 1));
            check("frame_done", 32'(frame_done), 32'(cyc == W * W + 3));
            if (window_valid) begin
                r0 = wcnt / nw;
                c0 = wcnt % nw;
                for (int r = 0; r < KMAX; r++) begin
                    for (int c = 0; c < KMAX; c++) begin
                        e = (r < ki && c < ki) ? 32'((int'(base) + (r0 + r) * W + c0 + c) % 4096) : 32'd0;
                        check($sformatf("pe[%0d][%0d] window %0d", r, c, wcnt), pe_windows[r][c], e);
                    end
                end
                if (wcnt == 0) first_tl = pe_windows[0][0];
                last_tl = pe_windows[0][0];
                last_br = pe_windows[km1][km1];
                wcnt++;
            end else if (wcnt > 0) begin
                check("hold", pe_windows[0][0], last_tl);
            end
        end
    endtask

    initial begin
        int          wcnt;
        logic [31:0] ftl, ltl, lbr;

        vecs[0] = '{3'd5, 12'd0,    1'b0, 16, 32'd0,    32'd27,  32'd63};
        vecs[1] = '{3'd2, 12'd0,    1'b0, 49, 32'd0,    32'd54,  32'd63};
        vecs[2] = '{3'd1, 12'd100,  1'b0, 64, 32'd100,  32'd163, 32'd163};
        vecs[3] = '{3'd3, 12'd4094, 1'b0, 36, 32'd4094, 32'd43,  32'd61};
        vecs[4] = '{3'd5, 12'd0,    1'b1, 16, 32'd0,    32'd27,  32'd63};
        vecs[5] = '{3'd5, 12'd0,    1'b0, 16, 32'd0,    32'd27,  32'd63};

        rstn = 1'b0;
        start = 1'b0;
        ker_size = 3'd1;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("reset bram_en", 32'(bram_en), 32'd0);
        check("reset bram_addr", 32'(bram_addr), 32'd0);
        check("reset window_valid", 32'(window_valid), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset pe[0][0]", pe_windows[0][0], 32'd0);
        check("reset pe[4][4]", pe_windows[4][4], 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Frames run back to back: each start lands in the cycle after frame_done.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].k, vecs[i].base, vecs[i].poke, W * W + 3, wcnt, ftl, ltl, lbr);
            check($sformatf("vec%0d window count", i), 32'(wcnt), 32'(vecs[i].exp_windows));
            check($sformatf("vec%0d first top-left", i), ftl, vecs[i].exp_first_tl);
            check($sformatf("vec%0d last top-left", i), ltl, vecs[i].exp_last_tl);
            check($sformatf("vec%0d last bottom-right", i), lbr, vecs[i].exp_last_br);
        end

        // Mid-frame reset, then a clean K=2 frame.
        run_frame(3'd3, 12'd0, 1'b0, 30, wcnt, ftl, ltl, lbr);
        check("pre-reset top-left", ltl, 32'd9);
        rstn = 1'b0;
        @(negedge clk);
        check("midreset bram_en", 32'(bram_en), 32'd0);
        check("midreset bram_addr", 32'(bram_addr), 32'd0);
        check("midreset window_valid", 32'(window_valid), 32'd0);
        check("midreset frame_done", 32'(frame_done), 32'd0);
        for (int r = 0; r < KMAX; r++) begin
            for (int c = 0; c < KMAX; c++) begin
                check($sformatf("midreset pe[%0d][%0d]", r, c), pe_windows[r][c], 32'd0);
            end
        end
        rstn = 1'b1;
        run_frame(3'd2, 12'd0, 1'b0, W * W + 3, wcnt, ftl, ltl, lbr);
        check("post-reset window count", 32'(wcnt), 32'd49);
        check("post-reset first top-left", ftl, 32'd0);
        check("post-reset last top-left", ltl, 32'd54);
        check("post-reset last bottom-right", lbr, 32'd63);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
